// File: rtl/alu_cmd_issuer_if.sv
// Command, ALU operand/result and response signals of alu_cmd_issuer.
// slave = issuer side, master = command source plus the ALU it fronts.
interface alu_cmd_issuer_if #(
  parameter int W   = 8,
  parameter int OPW = 3
);
  logic           cmd_valid_i;
  logic           cmd_ready_o;
  logic [OPW-1:0] cmd_op_i;
  logic [W-1:0]   cmd_a_i;
  logic [W-1:0]   cmd_b_i;
  logic           cmd_acc_i;
  logic [W-1:0]   alu_a_o;
  logic [W-1:0]   alu_b_o;
  logic [OPW-1:0] alu_op_o;
  logic [W-1:0]   alu_res_i;
  logic           rsp_valid_o;
  logic           rsp_ready_i;
  logic [W-1:0]   rsp_data_o;
  logic           rsp_zero_o;
  logic [W-1:0]   acc_o;

  modport slave (
    input  cmd_valid_i, cmd_op_i, cmd_a_i, cmd_b_i, cmd_acc_i, alu_res_i, rsp_ready_i,
    output cmd_ready_o, alu_a_o, alu_b_o, alu_op_o, rsp_valid_o, rsp_data_o, rsp_zero_o, acc_o
  );

  modport master (
    output cmd_valid_i, cmd_op_i, cmd_a_i, cmd_b_i, cmd_acc_i, alu_res_i, rsp_ready_i,
    input  cmd_ready_o, alu_a_o, alu_b_o, alu_op_o, rsp_valid_o, rsp_data_o, rsp_zero_o, acc_o
  );
endinterface

// File: rtl/alu_cmd_issuer.sv
// ALU command issuer with chaining accumulator; result on rsp 2 cycles after cmd handshake, 1 op per 3 cycles.
// rsp held until rsp_ready_i, cmd_ready_o only in IDLE; ALU_CMD_ISSUER_OPCNT_EN adds op_cnt_o.
module alu_cmd_issuer #(
  parameter int W   = 8,
  parameter int OPW = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  alu_cmd_issuer_if.slave bus
`ifdef ALU_CMD_ISSUER_OPCNT_EN
  ,
  output logic [15:0]     op_cnt_o
`endif
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t         state_q, state_d;
  logic           cmd_hs, rsp_hs;
  logic [W-1:0]   a_q, b_q, data_q, acc_q;
  logic [OPW-1:0] op_q;
  logic           vld_q, zero_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    cmd_hs  = 1'b0;
    rsp_hs  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.cmd_valid_i) begin
          cmd_hs  = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: state_d = RESP;
      RESP: begin
        if (vld_q && bus.rsp_ready_i) begin
          rsp_hs  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Operands stay frozen outside ISSUE so the ALU output is stable when captured.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= '0;
      data_q <= '0;
      acc_q  <= '0;
      zero_q <= 1'b0;
      vld_q  <= 1'b0;
    end else begin
      if (cmd_hs) begin
        op_q <= bus.cmd_op_i;
        b_q  <= bus.cmd_b_i;
        a_q  <= bus.cmd_acc_i ? acc_q : bus.cmd_a_i;
      end
      if (state_q == ISSUE) begin
        data_q <= bus.alu_res_i;
        acc_q  <= bus.alu_res_i;
        zero_q <= (bus.alu_res_i == '0);
        vld_q  <= 1'b1;
      end
      if (rsp_hs) vld_q <= 1'b0;
    end
  end

`ifdef ALU_CMD_ISSUER_OPCNT_EN
  logic [15:0] op_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      op_cnt_q <= '0;
    else if (rsp_hs) op_cnt_q <= op_cnt_q + 16'd1;
  end

  assign op_cnt_o = op_cnt_q;
`endif

  assign bus.cmd_ready_o = (state_q == IDLE);
  assign bus.alu_a_o     = a_q;
  assign bus.alu_b_o     = b_q;
  assign bus.alu_op_o    = op_q;
  assign bus.rsp_valid_o = vld_q;
  assign bus.rsp_data_o  = data_q;
  assign bus.rsp_zero_o  = zero_q;
  assign bus.acc_o       = acc_q;

endmodule

// File: doc/alu_cmd_issuer.md
Name: alu_cmd_issuer

Overview:
- Command-side initiator for the team's 8-bit combinational ALU (3-bit opcode, operands A/B, 8-bit result).
- Accepts operation commands over a valid/ready handshake and drives registered operands and opcode to the ALU.
- Captures the ALU result and returns it over a second valid/ready handshake.
- Keeps an 8-bit accumulator so that results can be chained into the next operand A.

Parameters:
- W, 8, operand/result width; must match the ALU.
- OPW, 3, opcode width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- cmd_valid_i  in  1  command valid.
- cmd_ready_o  out  1  command ready; high only in IDLE.
- cmd_op_i  in  OPW  opcode: 000 ADD, 001 SUB, 010 SLL, 011 LSR, 100 AND, 101 OR, 110 XOR, 111 EQL.
- cmd_a_i  in  W  operand A.
- cmd_b_i  in  W  operand B.
- cmd_acc_i  in  1  1 = use the accumulator as operand A and ignore cmd_a_i.
- alu_a_o  out  W  operand A to the ALU (registered).
- alu_b_o  out  W  operand B to the ALU (registered).
- alu_op_o  out  OPW  opcode to the ALU (registered).
- alu_res_i  in  W  combinational result from the ALU.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  response ready.
- rsp_data_o  out  W  captured result.
- rsp_zero_o  out  1  1 when rsp_data_o == 0.
- acc_o  out  W  current accumulator value.

Behaviour:
- States: IDLE, ISSUE, RESP. Reset state is IDLE.
- On reset, all registered outputs are 0: alu_a_o, alu_b_o, alu_op_o, rsp_data_o, rsp_valid_o, rsp_zero_o, acc_o.
  - Consequently rsp_zero_o is 0 during reset even though rsp_data_o is 0; it is a register, not decoded.
- cmd_ready_o = (state == IDLE). It is combinational from state only and never depends on cmd_valid_i.
- IDLE: when cmd_valid_i && cmd_ready_o at an edge:
  - alu_op_o <= cmd_op_i; alu_b_o <= cmd_b_i;
  - alu_a_o <= cmd_acc_i ? acc : cmd_a_i;
  - go to ISSUE.
- IDLE without a handshake: hold all state.
- ISSUE (exactly 1 cycle): the ALU evaluates the registered operands combinationally. At the end of the cycle:
  - rsp_data_o <= alu_res_i; acc <= alu_res_i;
  - rsp_zero_o <= (alu_res_i == 0); rsp_valid_o <= 1;
  - go to RESP.
- RESP: rsp_valid_o, rsp_data_o and rsp_zero_o are held stable until rsp_valid_o && rsp_ready_i at an edge; then rsp_valid_o <= 0 and go to IDLE.
- Latency: the result is visible on rsp_data_o 2 cycles after the command handshake edge.
  - Peak throughput is one command per 3 cycles (IDLE, ISSUE, RESP, each with ready held high).
  - No overlap of commands.
- alu_a_o/alu_b_o/alu_op_o hold their last values outside ISSUE and change only on a command handshake.
- The accumulator updates on every completed operation, whether or not cmd_acc_i was set. It is not cleared except by reset.
- Arithmetic is entirely inside the ALU; this block performs no width extension.
  - Wrap-around results, e.g. SUB underflow, are passed through unmodified.
- rsp_ready_i high while in IDLE or ISSUE has no effect.
- cmd_valid_i high outside IDLE is ignored. The command is not latched and must be held by the source until cmd_ready_o.
- Asynchronous reset mid-operation, in ISSUE or RESP:
  - the in-flight operation is dropped;
  - rsp_valid_o falls immediately;
  - the FSM is in IDLE with acc = 0 on the first edge after rst_n deasserts.

Optional Feature:
- Macro: ALU_CMD_ISSUER_OPCNT_EN.
- Defined: adds port op_cnt_o (out, 16 bits), reset 0.
  - Increments by 1 on every response handshake; wraps from 16'hFFFF to 16'h0000.
  - Does not count operations dropped by reset.
- Not defined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- Reset, then ADD a=8'h0F b=8'h01, rsp_ready_i held 1 -> alu_op_o=000, alu_a_o=0F, alu_b_o=01 in the cycle after the handshake; rsp_data_o=8'h10 and rsp_valid_o=1 two cycles after the handshake; acc_o=8'h10; cmd_ready_o back to 1 one cycle after the response handshake.
- Chain: ADD 05+03 -> rsp 8'h08; then ADD with cmd_acc_i=1, cmd_a_i=8'hFF, b=02 -> alu_a_o=08, rsp 8'h0A, acc_o=8'h0A.
- SUB a=03 b=05 -> rsp 8'hFE, rsp_zero_o=0. Then XOR a=5A b=5A -> rsp 8'h00, rsp_zero_o=1.
- Backpressure: EQL a=55 b=55, rsp_ready_i low for 4 cycles -> rsp_valid_o=1 and rsp_data_o=8'h01 stable for all 4 cycles, cmd_ready_o=0, a second cmd_valid_i is ignored; after ready goes high, the FSM returns to IDLE and the second command is accepted.
- Reset mid-op: assert rst_n=0 during ISSUE -> rsp_valid_o=0, acc_o=0 and all ALU outputs 0 immediately; after release, cmd_ready_o=1.
- With ALU_CMD_ISSUER_OPCNT_EN: 3 completed ops -> op_cnt_o=3. Force the counter to 16'hFFFF and complete one op -> op_cnt_o=0.
